// File: rtl/fp_pack_pkg.sv
// ============================================================================
//  Module      : fp_pack_pkg
//  Description : Shared encodings, flag indices and types for fp_result_pack.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pack_pkg;

    localparam logic [2:0] FPU_OP_MUL = 3'd2;
    localparam logic [2:0] FPU_OP_DIV = 3'd3;
    localparam logic [2:0] FPU_OP_I2F = 3'd4;
    localparam logic [2:0] FPU_OP_F2I = 3'd5;

    localparam int FLAG_W      = 4;
    localparam int FLAG_INF    = 3;
    localparam int FLAG_OVF    = 2;
    localparam int FLAG_ZERO   = 1;
    localparam int FLAG_OP_ERR = 0;

    typedef struct packed {
        logic inf;
        logic ovf;
        logic zero;
        logic op_err;
    } fp_flags_t;

    typedef struct packed {
        logic mul;
        logic div;
        logic i2f;
        logic f2i;
    } fp_op_dec_t;

    function automatic fp_op_dec_t fp_decode(input logic [2:0] op);
        fp_op_dec_t d;
        d.mul = (op == FPU_OP_MUL);
        d.div = (op == FPU_OP_DIV);
        d.i2f = (op == FPU_OP_I2F);
        d.f2i = (op == FPU_OP_F2I);
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_pack_stage.sv
// ============================================================================
//  Module      : fp_pack_stage
//  Description : One valid/data pipeline register with ready/valid handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_pack_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         stage_ready;

    // An empty stage always accepts, which is what collapses bubbles.
    always_comb begin
        stage_ready = !valid_q || out_ready;
        valid_d     = valid_q;
        data_d      = data_q;
        if (stage_ready) begin
            valid_d = in_valid;
        end
        if (stage_ready && in_valid) begin
            data_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

`default_nettype wire

// File: rtl/fp_result_pack.sv
// ============================================================================
//  Module      : fp_result_pack
//  Description : FPU result special-case selection and packing, DEPTH-stage
//                elastic output pipeline. FP_PACK_STICKY_EN adds sticky flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_result_pack
    import fp_pack_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                fpu_op,
    input  logic [1:0]                rmode,
    input  logic                      sign_in,
    input  logic [EXP_W-1:0]          exp_rnd,
    input  logic [FRAC_W-1:0]         fract_rnd,
    input  logic [1:0]                exp_ovf,
    input  logic                      inf_out,
    input  logic                      ovf0,
    input  logic                      output_zero,
    input  logic                      max_num,
    input  logic                      f2i_max,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     result,
    output logic [FLAG_W-1:0]         flags
`ifdef FP_PACK_STICKY_EN
    ,
    input  logic                      clr_sticky,
    output logic [FLAG_W-1:0]         sticky
`endif
);

    localparam int RES_W = 1 + EXP_W + FRAC_W;
    localparam int PW    = RES_W + FLAG_W;

    localparam logic [EXP_W-1:0]  EXP_ONES    = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0]  EXP_ONES_M1 = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [FRAC_W-1:0] FRAC_ONES   = {FRAC_W{1'b1}};

    fp_op_dec_t          op_dec;
    logic                op_err;
    logic                div_ovf_inf;
    logic [EXP_W-1:0]    exp_final;
    logic [FRAC_W-1:0]   fract_final;
    logic [FLAG_W-1:0]   flags_new;

    always_comb begin
        op_dec      = fp_decode(fpu_op);
        op_err      = fpu_op[2] && fpu_op[1] && !(|op_dec);
        div_ovf_inf = op_dec.div && (exp_ovf == 2'b11);

        if (inf_out || ovf0 || output_zero) begin
            fract_final = '0;
        end else if (max_num || (f2i_max && op_dec.f2i)) begin
            fract_final = FRAC_ONES;
        end else begin
            fract_final = fract_rnd;
        end

        // Divide overflow saturates to infinity only under round-to-nearest.
        if ((op_dec.div && (exp_ovf == 2'b10)) || output_zero) begin
            exp_final = '0;
        end else if ((div_ovf_inf && (rmode == 2'b00)) || inf_out
                     || (f2i_max && op_dec.f2i)) begin
            exp_final = EXP_ONES;
        end else if (max_num) begin
            exp_final = EXP_ONES_M1;
        end else begin
            exp_final = exp_rnd;
        end

        flags_new              = '0;
        flags_new[FLAG_INF]    = (exp_final == EXP_ONES) && (fract_final == '0);
        flags_new[FLAG_OVF]    = ovf0 || div_ovf_inf;
        flags_new[FLAG_ZERO]   = output_zero;
        flags_new[FLAG_OP_ERR] = op_err;
    end

    // Index 0 is the input port, index k+1 is the output of stage k.
    logic [DEPTH:0]          stg_valid;
    logic [DEPTH:0][PW-1:0]  stg_data;
    logic [DEPTH:0]          stg_ready;

    assign stg_valid[0] = in_valid;
    assign stg_data[0]  = {sign_in, exp_final, fract_final, flags_new};

    always_comb begin
        stg_ready        = '0;
        stg_ready[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            stg_ready[k] = !stg_valid[k+1] || stg_ready[k+1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        fp_pack_stage #(
            .W (PW)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (stg_valid[k]),
            .in_data   (stg_data[k]),
            .out_ready (stg_ready[k+1]),
            .out_valid (stg_valid[k+1]),
            .out_data  (stg_data[k+1])
        );
    end

    fp_flags_t out_flags;

    assign in_ready  = stg_ready[0];
    assign out_valid = stg_valid[DEPTH];
    assign result    = stg_data[DEPTH][PW-1:FLAG_W];
    assign out_flags = stg_data[DEPTH][FLAG_W-1:0];
    assign flags     = out_flags;

`ifdef FP_PACK_STICKY_EN
    logic [FLAG_W-1:0] sticky_q, sticky_d;
    logic [FLAG_W-1:0] xfer_flags;

    // A clear in the same cycle as a transfer keeps only that transfer's flags.
    always_comb begin
        xfer_flags = (out_valid && out_ready) ? flags : '0;
        sticky_d   = clr_sticky ? xfer_flags : (sticky_q | xfer_flags);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky = sticky_q;
`endif

endmodule

`default_nettype wire
